instr_loader: RTL and testbench
===============================

# instr_loader

Instruction-memory loader feeding the fetch stage. Collects a byte stream from the UART receiver, assembles 32-bit instruction words MSB-first, and writes them to consecutive instruction-memory words starting at word 0. Loading stops after the word whose opcode field is HALT (6'b111111) has been written. That is the same opcode the control unit decodes into its halt signal, so the loaded program always ends in a halt the pipeline recognises.

## Interface
Parameters:
- NB_DATA, 32, instruction width
- NB_BYTE, 8, UART byte width
- NB_ADDR, 8, instruction-memory word-address width (2^NB_ADDR words)
- NB_OP, 6, opcode field width, bits [NB_DATA-1 : NB_DATA-NB_OP]
- HALT_OPCODE, 6'b111111, opcode value that terminates loading

Ports:
- clock_i  in  1  system clock, rising edge
- reset_n_i  in  1  reset; **one clock, reset asynchronous and active-low**
- start_i  in  1  arm loading; honoured only in IDLE or DONE
- rx_data_i  in  NB_BYTE  received byte
- rx_valid_i  in  1  one-cycle strobe qualifying rx_data_i
- busy_o  out  1  high in RECEIVE, WRITE, CHECK
- wr_en_o  out  1  one-cycle instruction-memory write strobe
- wr_addr_o  out  NB_ADDR  word address of the write
- wr_data_o  out  NB_DATA  assembled instruction
- word_count_o  out  NB_ADDR+1  words written since last start, HALT word included
- load_done_o  out  1  level; high in DONE until the next start_i
- overflow_o  out  1  memory filled without HALT
- checksum_err_o  out  1  checksum mismatch; tied 0 without LOADER_CHECKSUM_EN

## Operation
- Reset: state IDLE. All outputs, the byte counter, the address and the assembly register are 0. Memory contents are untouched.
- IDLE / DONE + start_i=1:
  - go to RECEIVE
  - clear address, word_count_o, overflow_o, checksum_err_o, load_done_o and the checksum accumulator
- RECEIVE, each rx_valid_i:
  - shift the byte in: word = {word[23:0], rx_data_i}
  - increment the 2-bit byte counter
  - XOR the byte into the checksum accumulator
  - on the 4th byte, go to WRITE
- WRITE (exactly one cycle):
  - wr_en_o=1, wr_addr_o=current address, wr_data_o=word
  - word_count_o increments; address increments and wraps modulo 2^NB_ADDR
  - next state:
    - word[31:26]==HALT_OPCODE → CHECK (macro on) or DONE
    - address == 2^NB_ADDR-1 and not HALT → overflow_o=1, DONE
    - otherwise → RECEIVE
- rx_valid_i during WRITE: accepted as byte 0 of the next word when the next state is RECEIVE, otherwise dropped. No byte is ever lost mid-program.
- DONE: load_done_o=1. rx_valid_i is ignored.
- start_i in RECEIVE, WRITE or CHECK is ignored.
- A start_i and an rx_valid_i in the same cycle in IDLE/DONE: start wins and the byte is dropped.

## Timing
- wr_en_o rises the cycle after the clock edge that samples the 4th rx_valid_i.
- Byte-to-write latency is 1 cycle.
- load_done_o rises the cycle after the HALT write (macro off), or the cycle after the checksum byte is sampled (macro on).
- All outputs are registered; nothing is combinational from the inputs.
- wr_addr_o/wr_data_o hold their last values when wr_en_o=0.
- Minimum byte spacing is 1 cycle: back-to-back strobes are supported, including across WRITE.

## Configuration
- LOADER_CHECKSUM_EN defined: after the HALT write, enter CHECK and wait for one more byte.
  - checksum_err_o = (byte != XOR of all program bytes, HALT bytes included)
  - then go to DONE
  - overflow bypasses CHECK
- LOADER_CHECKSUM_EN undefined:
  - no CHECK state, no accumulator
  - checksum_err_o constant 0
  - HALT goes directly to DONE

## Structure
- Shared package loader_pkg:
  - state encoding: IDLE, RECEIVE, WRITE, CHECK, DONE
  - HALT_OPCODE, NB_BYTE, NB_OP
  - the same HALT constant is used by the control unit
- One sub-module, byte_assembler:
  - shift register, 2-bit byte counter and word_ready pulse
  - the FSM, address counter and checksum stay in instr_loader

## Test plan
- Reset mid-RECEIVE after 2 bytes → all outputs 0, IDLE; the next start with 4 bytes 0x20,0x01,0x00,0x05 → one write, addr 0, data 0x20010005.
- start, bytes for 0x8C220004 then 0xFC000000 → writes at addr 0 and 1, word_count_o=2, load_done_o one cycle after the 2nd write, busy_o low.
- Back-to-back strobes, 8 consecutive cycles (0x00..0x07) then HALT → data 0x00010203, 0x04050607, no dropped byte.
- NB_ADDR=2, 4 non-HALT words → writes addr 0..3, overflow_o=1, load_done_o=1, word_count_o=4.
- start_i during RECEIVE, and rx_valid_i in DONE → no effect on address, count or writes.
- LOADER_CHECKSUM_EN defined: program 0xFC000000, then check byte 0xFC → checksum_err_o=0; check byte 0x00 → checksum_err_o=1.

Source files
------------

// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction-memory loader.
//   - state_t     : loader FSM state encoding (IDLE, RECEIVE, WRITE, CHECK, DONE)
//   - NB_BYTE     : UART byte width
//   - NB_OP       : opcode field width
//   - HALT_OPCODE : opcode that ends a program; the control unit decodes the
//                   same constant into its halt signal, so both sides agree
//                   on what a loaded program's last word looks like.
// ---------------------------------------------------------------------------
package loader_pkg;

  localparam int NB_BYTE = 8;
  localparam int NB_OP   = 6;

  localparam logic [NB_OP-1:0] HALT_OPCODE = 6'b111111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RECEIVE = 3'd1,
    ST_WRITE   = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/byte_assembler.sv
// ---------------------------------------------------------------------------
// byte_assembler
// Collects bytes MSB-first into an NB_DATA-bit word.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clear      in   drop any partially assembled word
//   shift_en   in   accept byte_in this cycle
//   byte_in    in   NB_BYTE data byte
//   word_next  out  assembled word including byte_in (valid with word_ready)
//   word_ready out  pulse: byte_in is the last byte of the current word
// Only the leading bytes are stored; the final byte is appended
// combinationally so the loader can register the whole word on the same
// edge that samples it.
// ---------------------------------------------------------------------------
module byte_assembler #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [NB_BYTE-1:0] byte_in,
  output logic [NB_DATA-1:0] word_next,
  output logic               word_ready
);

  localparam int NB_PART = NB_DATA - NB_BYTE;

  logic [NB_PART-1:0] part_reg;
  logic [1:0]         cnt_reg;

  assign word_next  = {part_reg, byte_in};
  assign word_ready = shift_en && (cnt_reg == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      part_reg <= '0;
      cnt_reg  <= 2'd0;
    end else if (clear) begin
      part_reg <= '0;
      cnt_reg  <= 2'd0;
    end else if (shift_en) begin
      part_reg <= word_next[NB_PART-1:0];
      cnt_reg  <= cnt_reg + 2'd1;   // wraps to 0 after the 4th byte
    end
  end

endmodule

// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
// Loads a program from the UART byte stream into instruction memory,
// word 0 upward, until the HALT-opcode word has been written.
// Optional feature macro: LOADER_CHECKSUM_EN -- after the HALT write, one
// more byte is received and compared with the XOR of all program bytes.
// Ports:
//   clock_i        in   clock, rising edge
//   reset_n_i      in   asynchronous active-low reset
//   start_i        in   arm loading (honoured in IDLE/DONE only)
//   rx_data_i      in   received byte
//   rx_valid_i     in   strobe qualifying rx_data_i
//   busy_o         out  high in RECEIVE, WRITE, CHECK
//   wr_en_o        out  one-cycle memory write strobe
//   wr_addr_o      out  word address of the write
//   wr_data_o      out  assembled instruction
//   word_count_o   out  words written since last start
//   load_done_o    out  high in DONE until next start
//   overflow_o     out  memory filled without a HALT word
//   checksum_err_o out  checksum mismatch (0 without LOADER_CHECKSUM_EN)
// ---------------------------------------------------------------------------
module instr_loader #(
  parameter int                NB_DATA     = 32,
  parameter int                NB_BYTE     = loader_pkg::NB_BYTE,
  parameter int                NB_ADDR     = 8,
  parameter int                NB_OP       = loader_pkg::NB_OP,
  parameter logic [NB_OP-1:0]  HALT_OPCODE = loader_pkg::HALT_OPCODE
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  logic [NB_BYTE-1:0] rx_data_i,
  input  logic               rx_valid_i,
  output logic               busy_o,
  output logic               wr_en_o,
  output logic [NB_ADDR-1:0] wr_addr_o,
  output logic [NB_DATA-1:0] wr_data_o,
  output logic [NB_ADDR:0]   word_count_o,
  output logic               load_done_o,
  output logic               overflow_o,
  output logic               checksum_err_o
);
  import loader_pkg::*;

  state_t             state_reg;
  logic [NB_ADDR-1:0] addr_reg;
  logic [NB_ADDR:0]   count_reg;
  logic [NB_ADDR-1:0] wr_addr_reg;
  logic [NB_DATA-1:0] wr_data_reg;
  logic               wr_en_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               ovf_reg;

  logic [NB_DATA-1:0] word_next;
  logic               word_ready;
  logic               start_accept;
  logic               halt_word;
  logic               last_addr;
  logic               write_continues;
  logic               shift_en;

  assign start_accept = start_i && (state_reg == ST_IDLE || state_reg == ST_DONE);

  // Decided from the registered write word, so valid throughout WRITE.
  assign halt_word = (wr_data_reg[NB_DATA-1 -: NB_OP] == HALT_OPCODE);
  assign last_addr = (addr_reg == {NB_ADDR{1'b1}});

  // A byte arriving during WRITE starts the next word only if loading goes on.
  assign write_continues = (state_reg == ST_WRITE) && !halt_word && !last_addr;
  assign shift_en = rx_valid_i && ((state_reg == ST_RECEIVE) || write_continues);

  byte_assembler #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_byte_assembler (
    .clk        (clock_i),
    .rst_n      (reset_n_i),
    .clear      (start_accept),
    .shift_en   (shift_en),
    .byte_in    (rx_data_i),
    .word_next  (word_next),
    .word_ready (word_ready)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [NB_BYTE-1:0] csum_reg;
  logic               err_reg;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      csum_reg <= '0;
    end else if (start_accept) begin
      csum_reg <= '0;
    end else if (shift_en) begin
      csum_reg <= csum_reg ^ rx_data_i;
    end
  end

  assign checksum_err_o = err_reg;
`else
  assign checksum_err_o = 1'b0;
`endif

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      count_reg   <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      wr_en_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      err_reg     <= 1'b0;
`endif
    end else begin
      wr_en_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_reg <= ST_RECEIVE;
            busy_reg  <= 1'b1;
            addr_reg  <= '0;
            count_reg <= '0;
            done_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            err_reg   <= 1'b0;
`endif
          end
        end
        ST_RECEIVE: begin
          if (word_ready) begin
            state_reg   <= ST_WRITE;
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= addr_reg;
            wr_data_reg <= word_next;
          end
        end
        ST_WRITE: begin
          count_reg <= count_reg + (NB_ADDR+1)'(1);
          addr_reg  <= addr_reg + NB_ADDR'(1);
          if (halt_word) begin
`ifdef LOADER_CHECKSUM_EN
            state_reg <= ST_CHECK;
`else
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
`endif
          end else if (last_addr) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            ovf_reg   <= 1'b1;
          end else begin
            state_reg <= ST_RECEIVE;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (rx_valid_i) begin
            err_reg   <= (rx_data_i != csum_reg);
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
`endif
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = busy_reg;
  assign wr_en_o      = wr_en_reg;
  assign wr_addr_o    = wr_addr_reg;
  assign wr_data_o    = wr_data_reg;
  assign word_count_o = count_reg;
  assign load_done_o  = done_reg;
  assign overflow_o   = ovf_reg;

endmodule

// File: tb/tb_instr_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_loader
// Directed bench for instr_loader (NB_ADDR=2 so overflow is reachable).
// A transaction-level reference model tracks the loader from the byte stream;
// every cycle the DUT outputs are compared with it, and literal expectations
// on the write log pin the model. Honours LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_instr_loader;

  localparam int AW = 2;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          rxv = 1'b0;
  logic [7:0]    rxd = 8'h00;
  logic          busy, wr_en, load_done, overflow, checksum_err;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   word_count;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];

  always #5 clk = ~clk;

  instr_loader #(.NB_ADDR(AW)) dut (
    .clock_i        (clock_sig()),
    .reset_n_i      (rst_n),
    .start_i        (start),
    .rx_data_i      (rxd),
    .rx_valid_i     (rxv),
    .busy_o         (busy),
    .wr_en_o        (wr_en),
    .wr_addr_o      (wr_addr),
    .wr_data_o      (wr_data),
    .word_count_o   (word_count),
    .load_done_o    (load_done),
    .overflow_o     (overflow),
    .checksum_err_o (checksum_err)
  );

  function automatic logic clock_sig();
    return clk;
  endfunction

  // ---------------- reference model ----------------
  // Loader viewed as: armed or not, bytes gathered into words, a pending
  // write shown for one cycle, then finish on HALT / full memory / check byte.
  bit          m_active, m_done, m_check, m_ovf, m_err, m_wr_en;
  int          m_addr, m_count, m_nbytes;
  logic [AW-1:0] m_wr_addr;
  logic [31:0] m_wr_data, m_word;
  logic [7:0]  m_acc;

  task automatic m_take(input logic [7:0] b);
    m_word = {m_word[23:0], b};
    m_acc  = m_acc ^ b;
    m_nbytes++;
    if (m_nbytes == 4) begin
      m_nbytes  = 0;
      m_wr_en   = 1'b1;
      m_wr_addr = AW'(m_addr);
      m_wr_data = m_word;
    end
  endtask

  task automatic m_finish();
    m_active = 1'b0;
    m_done   = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_check = 0; m_ovf = 0; m_err = 0; m_wr_en = 0;
      m_addr = 0; m_count = 0; m_nbytes = 0;
      m_wr_addr = '0; m_wr_data = '0; m_word = '0; m_acc = '0;
    end else if (m_wr_en) begin
      int old_addr;
      old_addr = m_addr;
      m_wr_en  = 1'b0;
      m_count++;
      m_addr = (m_addr + 1) % (1 << AW);
      if (m_wr_data[31:26] == 6'b111111) begin
        if (CS) m_check = 1'b1;
        else    m_finish();
      end else if (old_addr == (1 << AW) - 1) begin
        m_ovf = 1'b1;
        m_finish();
      end else if (rxv) begin
        m_take(rxd);
      end
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_done = 0; m_ovf = 0; m_err = 0; m_check = 0;
        m_addr = 0; m_count = 0; m_nbytes = 0; m_word = '0; m_acc = '0;
      end
    end else if (m_check) begin
      if (rxv) begin
        m_err   = (rxd != m_acc);
        m_check = 1'b0;
        m_finish();
      end
    end else if (rxv) begin
      m_take(rxd);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic cmp_model();
    logic [AW+AW+38:0] got, exp;
    got = {busy, wr_en, wr_addr, wr_data, word_count, load_done, overflow, checksum_err};
    exp = {m_active, m_wr_en, m_wr_addr, m_wr_data, (AW+1)'(m_count), m_done, m_ovf, m_err};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL outputs cycle %0d: got busy/wr_en/addr/data/count/done/ovf/err=%h required %h",
               cycle, got, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One clock of stimulus, then compare at the falling edge.
  task automatic step(input bit s, input bit v, input logic [7:0] d);
    start = s; rxv = v; rxd = d;
    @(posedge clk);
    @(negedge clk);
    cycle++;
    cmp_model();
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      $display("write addr=%0d data=%h count_before=%0d", wr_addr, wr_data, word_count);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  // Four bytes MSB-first, one idle cycle after each.
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      step(1'b0, 1'b1, w[i*8 +: 8]);
      step(1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic send_check(input logic [7:0] b);
    if (CS) begin
      step(1'b0, 1'b1, b);
      step(1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    idle(2);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_wr_data", wr_data, 32'd0);
    chk("reset_count", 32'(word_count), 32'd0);
    chk("reset_done", 32'(load_done), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Reset in the middle of a word, then a clean load
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h20);
    step(1'b0, 1'b1, 8'h01);
    rst_n = 1'b0;
    idle(2);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(load_done), 32'd0);
    rst_n = 1'b1;
    idle(1);
    clear_log();
    step(1'b1, 1'b0, 8'h00);
    send_word(32'h20010005);
    chk("t1_nwrites", 32'(log_data.size()), 32'd1);
    chk("t1_data0", log_data[0], 32'h20010005);
    chk("t1_addr0", 32'(log_addr[0]), 32'd0);
    send_word(32'hFC000000);
    send_check(8'hD8);
    idle(2);

    // Two-word program
    clear_log();
    step(1'b1, 1'b0, 8'h00);
    send_word(32'h8C220004);
    send_word(32'hFC000000);
    send_check(8'h56);
    idle(2);
    chk("t2_nwrites", 32'(log_data.size()), 32'd2);
    chk("t2_data0", log_data[0], 32'h8C220004);
    chk("t2_data1", log_data[1], 32'hFC000000);
    chk("t2_addr1", 32'(log_addr[1]), 32'd1);
    chk("t2_count", 32'(word_count), 32'd2);
    chk("t2_done", 32'(load_done), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_err", 32'(checksum_err), 32'd0);

    // Back-to-back strobes straight through the WRITE cycles
    clear_log();
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(i));
    step(1'b0, 1'b1, 8'hFC);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
    idle(1);
    send_check(8'hFC);
    idle(2);
    chk("t3_nwrites", 32'(log_data.size()), 32'd3);
    chk("t3_data0", log_data[0], 32'h00010203);
    chk("t3_data1", log_data[1], 32'h04050607);
    chk("t3_addr2", 32'(log_addr[2]), 32'd2);
    chk("t3_count", 32'(word_count), 32'd3);

    // Fill all 4 words without HALT
    clear_log();
    step(1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 4; i++) send_word({8'(i), 24'h000000});
    idle(2);
    chk("t4_nwrites", 32'(log_data.size()), 32'd4);
    chk("t4_addr3", 32'(log_addr[3]), 32'd3);
    chk("t4_data3", log_data[3], 32'h04000000);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_done", 32'(load_done), 32'd1);
    chk("t4_count", 32'(word_count), 32'd4);
    chk("t4_busy", 32'(busy), 32'd0);

    // start during RECEIVE ignored; bytes in DONE ignored
    clear_log();
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h20); step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h02); step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00); step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h07); step(1'b0, 1'b0, 8'h00);
    send_word(32'hFC000000);
    send_check(8'hD9);
    idle(2);
    send_word(32'hAABBCCDD);
    idle(2);
    chk("t5_nwrites", 32'(log_data.size()), 32'd2);
    chk("t5_data0", log_data[0], 32'h20020007);
    chk("t5_count", 32'(word_count), 32'd2);
    chk("t5_done", 32'(load_done), 32'd1);

    // start and a byte in the same cycle: the byte is dropped
    clear_log();
    step(1'b1, 1'b1, 8'hAA);
    send_word(32'h11223344);
    chk("t6_nwrites", 32'(log_data.size()), 32'd1);
    chk("t6_data0", log_data[0], 32'h11223344);
    chk("t6_addr0", 32'(log_addr[0]), 32'd0);
    send_word(32'hFC000000);
    send_check(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'hFC);
    idle(2);

    // Checksum byte good / bad
    step(1'b1, 1'b0, 8'h00);
    send_word(32'hFC000000);
    send_check(8'hFC);
    idle(2);
    chk("t7_err_good", 32'(checksum_err), 32'd0);
    step(1'b1, 1'b0, 8'h00);
    send_word(32'hFC000000);
    send_check(8'h00);
    idle(2);
    chk("t7_err_bad", 32'(checksum_err), CS ? 32'd1 : 32'd0);
    chk("t7_done", 32'(load_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
